maf_res_chk: RTL and testbench



---
 rtl/maf_res_chk_pkg.sv | 44 ++++
 rtl/maf_res_chk_if.sv | 35 +++
 rtl/maf_res_chk_fifo.sv | 51 +++++
 rtl/maf_res_chk.sv | 140 ++++++++++++++
 tb/tb_maf_res_chk.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/maf_res_chk_pkg.sv
// Shared types and helpers for the maf result checker.
// Purpose: error codes, expected-entry struct, FSM states, FP32 match rule.
// Optional: MAF_CHK_ULP_TOL_EN widens the match rule to a 1-ulp tolerance.
package vfpu_dc_pkg;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MISMATCH = 3'd1;
  localparam logic [2:0] ERR_SPURIOUS = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } maf_exp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } chk_state_t;

  function automatic logic is_nan32(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Bit-exact compare, except any two NaNs are equivalent. +0/-0 differ on
  // purpose: the DUT must preserve the zero sign.
  function automatic logic res_match(input logic [31:0] e, input logic [31:0] r);
    logic m;
    m = (e == r) || (is_nan32(e) && is_nan32(r));
`ifdef MAF_CHK_ULP_TOL_EN
    // Non-NaN magnitudes never exceed 0x7F800000, so the 31-bit difference
    // cannot wrap into a false +/-1.
    if (!is_nan32(e) && !is_nan32(r) && (e[31] == r[31]) &&
        ((e[30:0] - r[30:0] == 31'd1) || (r[30:0] - e[30:0] == 31'd1)))
      m = 1'b1;
`endif
    return m;
  endfunction

endpackage

// File: rtl/maf_res_chk_if.sv
// Handshake/bus bundle between the test platform and maf_res_chk.
// master: platform side (drives operands/results, reads status).
// slave : checker side.
interface maf_res_chk_if #(
  parameter int CNT_W = 16
);
  logic             clr;
  logic             exp_vld;
  logic [31:0]      exp_res;
  logic [31:0]      exp_a;
  logic [31:0]      exp_b;
  logic [31:0]      exp_c;
  logic             res_rdy;
  logic [31:0]      res;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err;
  logic [2:0]       err_code;
  logic [31:0]      cap_a;
  logic [31:0]      cap_b;
  logic [31:0]      cap_c;
  logic [31:0]      cap_exp;
  logic [31:0]      cap_res;
  logic             halted;

  modport master (
    output clr, exp_vld, exp_res, exp_a, exp_b, exp_c, res_rdy, res,
    input  pass_cnt, fail_cnt, err, err_code, cap_a, cap_b, cap_c, cap_exp, cap_res, halted
  );

  modport slave (
    input  clr, exp_vld, exp_res, exp_a, exp_b, exp_c, res_rdy, res,
    output pass_cnt, fail_cnt, err, err_code, cap_a, cap_b, cap_c, cap_exp, cap_res, halted
  );
endinterface

// File: rtl/maf_res_chk_fifo.sv
// Expected-result alignment FIFO (maf_exp_t entries, DEPTH a power of 2).
// Latency: push visible at head next cycle; same-cycle push+pop legal when full.
// Backpressure: none; a push into a full FIFO without a pop is dropped.
// Ports: i_clr sync flush, i_push/i_dat write, i_pop read, o_dat head, o_full/o_empty.
module maf_chk_fifo
  import vfpu_dc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_clr,
  input  logic     i_push,
  input  maf_exp_t i_dat,
  input  logic     i_pop,
  output maf_exp_t o_dat,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = $clog2(DEPTH);

  maf_exp_t    r_mem [DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic        w_do_pop;
  logic        w_do_push;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dat     = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_clr) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr) r_mem[r_wp[AW-1:0]] <= i_dat;
  end
endmodule

// File: rtl/maf_res_chk.sv
// Result checker: aligns maf DUT results with expected results, FP32-compares,
// counts pass/fail, latches first error + failing transaction.
// Latency 1 (results registered the cycle after res_rdy); no backpressure.
// Ports: clk, rst_n (async active-low), bus (maf_res_chk_if.slave).
// Optional: define MAF_CHK_ULP_TOL_EN to accept 1-ulp differences.
module maf_res_chk
  import vfpu_dc_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 16,
  parameter int STOP_ON_ERR = 1
) (
  input logic          clk,
  input logic          rst_n,
  maf_res_chk_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  chk_state_t       r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_err;
  logic [2:0]       r_err_code;
  maf_exp_t         r_cap;
  logic [31:0]      r_cap_res;

  logic     w_active, w_exp_vld, w_res_rdy, w_full, w_empty;
  logic     w_bypass, w_cmp, w_spur, w_tmo, w_pop, w_push, w_ovf;
  logic     w_pass, w_fail, w_err_any;
  maf_exp_t w_in, w_head, w_ref, w_cap;
  logic [31:0] w_cap_res;
  logic [2:0]  w_code;

  // HALT freezes everything except clr.
  assign w_active  = (r_state != ST_HALT);
  assign w_exp_vld = bus.exp_vld && w_active;
  assign w_res_rdy = bus.res_rdy && w_active;
  assign w_in      = '{res: bus.exp_res, a: bus.exp_a, b: bus.exp_b, c: bus.exp_c};

  assign w_bypass  = w_empty && w_exp_vld && w_res_rdy;
  assign w_cmp     = w_res_rdy && (!w_empty || w_exp_vld);
  assign w_ref     = w_empty ? w_in : w_head;
  assign w_spur    = w_res_rdy && w_empty && !w_exp_vld;
  assign w_tmo     = !w_empty && !w_res_rdy && (r_to_cnt == TO_W'(TIMEOUT - 1));
  // A timed-out head is discarded through the normal pop path, which also
  // makes room for a same-cycle push.
  assign w_pop     = (w_res_rdy && !w_empty) || w_tmo;
  assign w_push    = w_exp_vld && !w_bypass;
  assign w_ovf     = w_push && w_full && !w_pop;
  assign w_pass    = w_cmp && res_match(w_ref.res, bus.res);
  assign w_fail    = w_cmp && !w_pass;
  assign w_err_any = w_fail || w_spur || w_ovf || w_tmo;

  maf_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (bus.clr),
    .i_push (w_push),
    .i_dat  (w_in),
    .i_pop  (w_pop),
    .o_dat  (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // What the first error would capture; mismatch and spurious exclude each
  // other, as do timeout and overflow (timeout frees a slot).
  always_comb begin
    w_code    = ERR_NONE;
    w_cap     = '0;
    w_cap_res = '0;
    if (w_fail) begin
      w_code    = ERR_MISMATCH;
      w_cap     = w_ref;
      w_cap_res = bus.res;
    end else if (w_spur) begin
      w_code    = ERR_SPURIOUS;
      w_cap_res = bus.res;
    end else if (w_ovf) begin
      w_code = ERR_OVERFLOW;
      w_cap  = w_in;
    end else if (w_tmo) begin
      w_code = ERR_TIMEOUT;
      w_cap  = w_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_cap      <= '0;
      r_cap_res  <= '0;
    end else if (bus.clr) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_cap      <= '0;
      r_cap_res  <= '0;
    end else if (w_active) begin
      if (w_err_any && (STOP_ON_ERR != 0))
        r_state <= ST_HALT;
      else if (r_state == ST_IDLE && (w_exp_vld || w_res_rdy))
        r_state <= ST_RUN;

      if (w_empty || w_pop) r_to_cnt <= '0;
      else                  r_to_cnt <= r_to_cnt + 1'b1;

      if (w_pass && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + 1'b1;
      if (w_fail && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + 1'b1;

      if (w_err_any && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
        r_cap      <= w_cap;
        r_cap_res  <= w_cap_res;
      end
    end
  end

  assign bus.pass_cnt = r_pass_cnt;
  assign bus.fail_cnt = r_fail_cnt;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;
  assign bus.cap_a    = r_cap.a;
  assign bus.cap_b    = r_cap.b;
  assign bus.cap_c    = r_cap.c;
  assign bus.cap_exp  = r_cap.res;
  assign bus.cap_res  = r_cap_res;
  assign bus.halted   = (r_state == ST_HALT);
endmodule

// File: tb/tb_maf_res_chk.sv
// Bench for maf_res_chk: directed vectors, queue-based reference model,
// per-cycle output compare plus literal spot checks.
module tb_maf_res_chk;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;
  localparam int STOP    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maf_res_chk_if #(.CNT_W(CNT_W)) bus ();

  maf_res_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .STOP_ON_ERR(STOP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, req);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ent_t;

  ent_t        q[$];
  longint      m_cyc   = 0;
  longint      m_since = 0;   // cycle at which the current head became head
  int          m_pass  = 0;
  int          m_fail  = 0;
  bit          m_err   = 0;
  bit          m_halt  = 0;
  int          m_code  = 0;
  ent_t        m_cap   = '0;
  logic [31:0] m_cres  = '0;

  function automatic bit m_ok(input logic [31:0] e, input logic [31:0] r);
    bit en = (e[30:23] == 8'hFF) && (e[22:0] != 0);
    bit rn = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    if (e === r) return 1'b1;
    if (en && rn) return 1'b1;
`ifdef MAF_CHK_ULP_TOL_EN
    if (!en && !rn && e[31] == r[31]) begin
      int d = int'(e[30:0]) - int'(r[30:0]);
      if (d == 1 || d == -1) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  task automatic m_reset();
    q.delete();
    m_pass = 0; m_fail = 0; m_err = 0; m_halt = 0; m_code = 0;
    m_cap = '0; m_cres = '0;
  endtask

  task automatic m_error(input int code, input ent_t e, input logic [31:0] r);
    if (!m_err) begin
      m_err = 1; m_code = code; m_cap = e; m_cres = r;
    end
    if (STOP != 0) m_halt = 1;
  endtask

  task automatic m_judge(input ent_t e, input logic [31:0] r);
    if (m_ok(e.res, r)) begin
      if (m_pass < (1 << CNT_W) - 1) m_pass++;
    end else begin
      if (m_fail < (1 << CNT_W) - 1) m_fail++;
      m_error(1, e, r);
    end
  endtask

  task automatic m_edge();
    ent_t in_e, hd;
    in_e = '{res: bus.exp_res, a: bus.exp_a, b: bus.exp_b, c: bus.exp_c};
    if (bus.res_rdy) begin
      if (q.size() > 0) begin
        hd = q.pop_front();
        m_since = m_cyc;
        m_judge(hd, bus.res);
        if (bus.exp_vld) q.push_back(in_e);
      end else if (bus.exp_vld) begin
        m_judge(in_e, bus.res);
      end else begin
        m_error(2, '0, bus.res);
      end
    end else begin
      if (q.size() > 0 && m_cyc == m_since + TIMEOUT) begin
        hd = q.pop_front();
        m_since = m_cyc;
        m_error(4, hd, '0);
      end
      if (bus.exp_vld) begin
        if (q.size() < DEPTH) begin
          if (q.size() == 0) m_since = m_cyc;
          q.push_back(in_e);
        end else begin
          m_error(3, in_e, '0);
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else begin
      m_cyc++;
      if (bus.clr) m_reset();
      else if (!m_halt) m_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("pass_cnt", 32'(bus.pass_cnt), 32'(m_pass));
      check("fail_cnt", 32'(bus.fail_cnt), 32'(m_fail));
      check("err",      32'(bus.err),      32'(m_err));
      check("err_code", 32'(bus.err_code), 32'(m_code));
      check("halted",   32'(bus.halted),   32'(m_halt));
      check("cap_a",    bus.cap_a,   m_cap.a);
      check("cap_b",    bus.cap_b,   m_cap.b);
      check("cap_c",    bus.cap_c,   m_cap.c);
      check("cap_exp",  bus.cap_exp, m_cap.res);
      check("cap_res",  bus.cap_res, m_cres);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit ev, input logic [31:0] e, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c,
                      input bit rr, input logic [31:0] r, input bit cl = 1'b0);
    bus.exp_vld = ev; bus.exp_res = e; bus.exp_a = a; bus.exp_b = b; bus.exp_c = c;
    bus.res_rdy = rr; bus.res = r; bus.clr = cl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, 0, '0);
  endtask

  task automatic do_clr();
    step(0, '0, '0, '0, '0, 0, '0, 1'b1);
  endtask

  localparam logic [31:0] ONE = 32'h3F800000, TWO = 32'h40000000, HALF = 32'h3F000000;

  initial begin
    bus.clr = 0; bus.exp_vld = 0; bus.exp_res = 0; bus.exp_a = 0; bus.exp_b = 0;
    bus.exp_c = 0; bus.res_rdy = 0; bus.res = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst pass_cnt", 32'(bus.pass_cnt), 32'd0);
    check("rst err",      32'(bus.err),      32'd0);
    check("rst err_code", 32'(bus.err_code), 32'd0);
    check("rst halted",   32'(bus.halted),   32'd0);
    check("rst cap_exp",  bus.cap_exp,       32'd0);

    // Bypass exact match, then a FIFO-aligned match.
    step(1, 32'h40200000, ONE, TWO, HALF, 1, 32'h40200000);
    check("bypass pass_cnt", 32'(bus.pass_cnt), 32'd1);
    check("bypass err",      32'(bus.err),      32'd0);
    step(1, 32'h40200000, ONE, TWO, HALF, 0, '0);
    check("queued pass_cnt", 32'(bus.pass_cnt), 32'd1);
    step(0, '0, '0, '0, '0, 1, 32'h40200000);
    check("aligned pass_cnt", 32'(bus.pass_cnt), 32'd2);

    // NaNs with different payload and sign are equivalent.
    step(1, 32'h7FC00000, ONE, TWO, HALF, 1, 32'hFFC00001);
    check("nan pass_cnt", 32'(bus.pass_cnt), 32'd3);

    // Fill, then push+pop while full, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1, ONE + 32'(i), '0, '0, '0, 0, '0);
    step(1, ONE + 32'(DEPTH), '0, '0, '0, 1, ONE);
    check("full push+pop err", 32'(bus.err), 32'd0);
    for (int i = 1; i <= DEPTH; i++) step(0, '0, '0, '0, '0, 1, ONE + 32'(i));
    check("drain pass_cnt", 32'(bus.pass_cnt), 32'd8);

    // Mismatch: capture, halt, later pass ignored.
    step(1, 32'h40200000, ONE, TWO, HALF, 1, 32'h40200002);
    check("mm fail_cnt", 32'(bus.fail_cnt), 32'd1);
    check("mm err_code", 32'(bus.err_code), 32'd1);
    check("mm cap_exp",  bus.cap_exp, 32'h40200000);
    check("mm cap_res",  bus.cap_res, 32'h40200002);
    check("mm cap_a",    bus.cap_a,   ONE);
    check("mm halted",   32'(bus.halted), 32'd1);
    step(1, 32'h40200000, ONE, TWO, HALF, 1, 32'h40200000);
    check("halt frozen pass", 32'(bus.pass_cnt), 32'd8);
    do_clr();
    check("clr halted",   32'(bus.halted),   32'd0);
    check("clr pass_cnt", 32'(bus.pass_cnt), 32'd0);
    check("clr err",      32'(bus.err),      32'd0);

    // +0 vs -0 is a failure.
    step(1, 32'h00000000, '0, '0, '0, 1, 32'h80000000);
    check("zero sign code", 32'(bus.err_code), 32'd1);
    do_clr();

    // Spurious result.
    step(0, '0, '0, '0, '0, 1, 32'h12345678);
    check("spur code",     32'(bus.err_code), 32'd2);
    check("spur pass_cnt", 32'(bus.pass_cnt), 32'd0);
    check("spur fail_cnt", 32'(bus.fail_cnt), 32'd0);
    do_clr();

    // Overflow on the fifth unpopped push.
    for (int i = 0; i < DEPTH; i++) step(1, TWO + 32'(i), '0, '0, '0, 0, '0);
    check("pre-ovf err", 32'(bus.err), 32'd0);
    step(1, 32'h4A000000, '0, '0, '0, 0, '0);
    check("ovf code", 32'(bus.err_code), 32'd3);
    do_clr();

    // Timeout exactly TIMEOUT cycles after the push.
    step(1, 32'h41000000, ONE, ONE, ONE, 0, '0);
    idle(TIMEOUT - 1);
    check("pre-tmo err", 32'(bus.err), 32'd0);
    idle(1);
    check("tmo code",    32'(bus.err_code), 32'd4);
    check("tmo cap_exp", bus.cap_exp, 32'h41000000);
    do_clr();

    // One-ulp difference.
    step(1, 32'h40200000, ONE, TWO, HALF, 1, 32'h40200001);
`ifdef MAF_CHK_ULP_TOL_EN
    check("ulp pass_cnt", 32'(bus.pass_cnt), 32'd1);
`else
    check("ulp err_code", 32'(bus.err_code), 32'd1);
`endif
    do_clr();

    // clr beats a same-cycle push.
    step(1, ONE, '0, '0, '0, 0, '0, 1'b1);
    step(0, '0, '0, '0, '0, 1, ONE);
    check("clr prio code", 32'(bus.err_code), 32'd2);
    do_clr();

    // Async reset mid-transaction flushes queued entries.
    step(1, ONE, '0, '0, '0, 0, '0);
    step(1, TWO, '0, '0, '0, 0, '0);
    bus.exp_vld = 0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    step(0, '0, '0, '0, '0, 1, ONE);
    check("arst flush code", 32'(bus.err_code), 32'd2);
    check("arst pass_cnt",   32'(bus.pass_cnt), 32'd0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
